// File: rtl/tx_seq_pkg.sv
// rtl/tx_seq_pkg.sv - shared types, Ethernet sizing constants and keep-mask helper for the tx frame sequencer
package tx_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int ETH_HDR_BYTES   = 14;
    localparam int ETH_MIN_PAYLOAD = 46;
    localparam int ETH_MAX_PAYLOAD = 1500;

    // Low min(remaining, data_bytes) bits set; callers slice to their beat width.
    function automatic logic [7:0] keep_mask(input int unsigned remaining,
                                             input int unsigned data_bytes);
        logic [7:0] m;
        m = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            m[i] = (i < remaining) && (i < data_bytes);
        end
        return m;
    endfunction

endpackage

// File: rtl/tx_beat_flags.sv
// rtl/tx_beat_flags.sv - combinational per-beat tlast/tkeep and header/payload/pad phase flags
module tx_beat_flags
    import tx_seq_pkg::*;
#(
    parameter int DATA_BYTES = 1,
    parameter int HDR_BYTES  = ETH_HDR_BYTES,
    parameter int LEN_W      = 16
) (
    input  logic                  valid,
    input  logic [LEN_W-1:0]      byte_idx,
    input  logic [LEN_W-1:0]      total,
    input  logic [LEN_W-1:0]      pbnd,
    output logic                  tlast,
    output logic [DATA_BYTES-1:0] tkeep,
    output logic                  hdr_active,
    output logic                  pay_start,
    output logic                  pad_active
);

    localparam int W = LEN_W + 1;

    logic [W-1:0]          beat_end;
    logic [W-1:0]          hi;
    logic [LEN_W-1:0]      remaining;
    logic                  is_last;
    logic [DATA_BYTES-1:0] last_keep;

    always_comb begin
        beat_end  = {1'b0, byte_idx} + W'(DATA_BYTES);
        remaining = total - byte_idx;
        is_last   = (beat_end >= {1'b0, total});
        // Highest byte of this beat that still lies inside the frame.
        hi        = is_last ? ({1'b0, total} - W'(1)) : (beat_end - W'(1));
        last_keep = DATA_BYTES'(keep_mask(32'(remaining), DATA_BYTES));

        tlast      = valid & is_last;
        tkeep      = !valid ? '0 : (is_last ? last_keep : '1);
        hdr_active = valid & (byte_idx < LEN_W'(HDR_BYTES));
        pay_start  = valid & (byte_idx <= LEN_W'(HDR_BYTES)) & (hi >= W'(HDR_BYTES));
        pad_active = valid & (hi >= {1'b0, pbnd});
    end

endmodule

// File: rtl/tx_frame_sequencer.sv
// rtl/tx_frame_sequencer.sv - frame request FSM, length clamp/pad latch, beat counter and inter-frame gap
module tx_frame_sequencer
    import tx_seq_pkg::*;
#(
    parameter int DATA_BYTES  = 1,
    parameter int HDR_BYTES   = ETH_HDR_BYTES,
    parameter int LEN_W       = 16,
    parameter int MIN_PAYLOAD = ETH_MIN_PAYLOAD,
    parameter int MAX_PAYLOAD = ETH_MAX_PAYLOAD,
    parameter int IFG_BEATS   = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_W-1:0]      payload_len,
    output logic                  start_rdy,
    output logic                  busy,
    output logic                  len_err,
    output logic                  tvalid,
    input  logic                  tready,
    output logic                  tlast,
    output logic [DATA_BYTES-1:0] tkeep,
    output logic [LEN_W-1:0]      byte_idx,
    output logic                  hdr_active,
    output logic                  pay_start,
    output logic                  pad_active
);

    localparam int IFG_W = (IFG_BEATS > 0) ? $clog2(IFG_BEATS + 1) : 1;

    if (HDR_BYTES + MAX_PAYLOAD >= (64'd1 << LEN_W)) begin : g_len_w_chk
        $error("tx_frame_sequencer: LEN_W too narrow for HDR_BYTES+MAX_PAYLOAD");
    end
    if (MIN_PAYLOAD > MAX_PAYLOAD) begin : g_min_max_chk
        $error("tx_frame_sequencer: MIN_PAYLOAD exceeds MAX_PAYLOAD");
    end
    if (DATA_BYTES != 1 && DATA_BYTES != 2 && DATA_BYTES != 4 && DATA_BYTES != 8) begin : g_db_chk
        $error("tx_frame_sequencer: DATA_BYTES must be 1, 2, 4 or 8");
    end

    state_t           state;
    logic [LEN_W-1:0] idx_q;
    logic [LEN_W-1:0] total_q;
    logic [LEN_W-1:0] pbnd_q;
    logic [IFG_W-1:0] ifg_cnt;
    logic             len_err_q;
    logic [LEN_W-1:0] raw_len;
    logic [LEN_W-1:0] eff_len;
    logic             beat_last;

    assign raw_len = (payload_len > LEN_W'(MAX_PAYLOAD)) ? LEN_W'(MAX_PAYLOAD) : payload_len;
    assign eff_len = (raw_len < LEN_W'(MIN_PAYLOAD)) ? LEN_W'(MIN_PAYLOAD) : raw_len;

    assign start_rdy = (state == IDLE);
    assign busy      = (state != IDLE);
    assign tvalid    = (state == SEND);
    assign byte_idx  = idx_q;
    assign len_err   = len_err_q;
    assign tlast     = beat_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx_q     <= '0;
            total_q   <= '0;
            pbnd_q    <= '0;
            ifg_cnt   <= '0;
            len_err_q <= 1'b0;
        end else begin
            len_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= SEND;
                        idx_q     <= '0;
                        total_q   <= LEN_W'(HDR_BYTES) + eff_len;
                        pbnd_q    <= LEN_W'(HDR_BYTES) + raw_len;
                        len_err_q <= (payload_len > LEN_W'(MAX_PAYLOAD));
                    end
                end
                SEND: begin
                    if (tready) begin
                        if (beat_last) begin
                            idx_q <= '0;
                            if (IFG_BEATS > 0) begin
                                state   <= GAP;
                                ifg_cnt <= IFG_W'(IFG_BEATS);
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            idx_q <= idx_q + LEN_W'(DATA_BYTES);
                        end
                    end
                end
                GAP: begin
                    // Count of 1 marks the final idle cycle of the gap.
                    if (ifg_cnt <= IFG_W'(1)) begin
                        state <= IDLE;
                    end else begin
                        ifg_cnt <= ifg_cnt - IFG_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    tx_beat_flags #(
        .DATA_BYTES (DATA_BYTES),
        .HDR_BYTES  (HDR_BYTES),
        .LEN_W      (LEN_W)
    ) u_flags (
        .valid      (tvalid),
        .byte_idx   (idx_q),
        .total      (total_q),
        .pbnd       (pbnd_q),
        .tlast      (beat_last),
        .tkeep      (tkeep),
        .hdr_active (hdr_active),
        .pay_start  (pay_start),
        .pad_active (pad_active)
    );

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// tb/tb_tx_frame_sequencer.sv - scoreboard bench for tx_frame_sequencer across DATA_BYTES 1/4/8/2
module tb_tx_frame_sequencer;

    localparam int NI = 4;

    function automatic int db_of(input int i);
        case (i)
            0:       return 1;
            1:       return 4;
            2:       return 8;
            default: return 2;
        endcase
    endfunction

    typedef struct packed {
        logic [15:0] idx;
        logic        last;
        logic [7:0]  keep;
        logic        hdr;
        logic        pay;
        logic        pad;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n       [NI];
    logic        start       [NI];
    logic        tready      [NI];
    logic [15:0] payload_len [NI];
    logic        start_rdy   [NI];
    logic        busy        [NI];
    logic        len_err     [NI];
    logic        tvalid      [NI];
    logic        tlast       [NI];
    logic        hdr_active  [NI];
    logic        pay_start   [NI];
    logic        pad_active  [NI];
    logic [7:0]  tkeep       [NI];
    logic [15:0] byte_idx    [NI];

    beat_t sb[$];
    int    n_cmp = 0;
    int    n_err = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < NI; i++) begin : g_dut
        localparam int DB = db_of(i);
        logic [DB-1:0] tk;
        tx_frame_sequencer #(.DATA_BYTES(DB)) u_dut (
            .clk         (clk),
            .rst_n       (rst_n[i]),
            .start       (start[i]),
            .payload_len (payload_len[i]),
            .start_rdy   (start_rdy[i]),
            .busy        (busy[i]),
            .len_err     (len_err[i]),
            .tvalid      (tvalid[i]),
            .tready      (tready[i]),
            .tlast       (tlast[i]),
            .tkeep       (tk),
            .byte_idx    (byte_idx[i]),
            .hdr_active  (hdr_active[i]),
            .pay_start   (pay_start[i]),
            .pad_active  (pad_active[i])
        );
        assign tkeep[i] = 8'(tk);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t observe(input int k);
        beat_t b;
        b.idx  = byte_idx[k];
        b.last = tlast[k];
        b.keep = tkeep[k];
        b.hdr  = hdr_active[k];
        b.pay  = pay_start[k];
        b.pad  = pad_active[k];
        return b;
    endfunction

    // Byte-by-byte reference model of one frame, pushed as expected beats.
    task automatic push_model(input int k, input int len);
        int db = db_of(k);
        int raw = (len > 1500) ? 1500 : len;
        int t = 14 + ((raw < 46) ? 46 : raw);
        int p = 14 + raw;
        for (int b = 0; b < t; b += db) begin
            beat_t e;
            e = '0;
            e.idx  = 16'(b);
            e.last = (b + db >= t);
            for (int j = 0; j < db; j++) begin
                int x = b + j;
                if (x < t) begin
                    e.keep[j] = 1'b1;
                    if (x < 14)  e.hdr = 1'b1;
                    if (x == 14) e.pay = 1'b1;
                    if (x >= p)  e.pad = 1'b1;
                end
            end
            sb.push_back(e);
        end
    endtask

    task automatic run_frame(input int k, input int len, input bit rnd,
                             output int nbeats, output int last_idx, output int last_keep);
        bit    done = 0;
        bit    have_snap = 0;
        beat_t snap = '0;
        int    cyc = 0;
        nbeats = 0; last_idx = -1; last_keep = -1;
        for (int c = 0; c < 100 && !start_rdy[k]; c++) @(negedge clk);
        chk("start_rdy_before_start", 32'(start_rdy[k]), 1);
        start[k] = 1'b1;
        payload_len[k] = 16'(len);
        tready[k] = 1'b1;
        push_model(k, len);
        while (!done && cyc < 5000) begin
            @(negedge clk);
            if (cyc == 0) begin
                start[k] = 1'b0;
                chk("len_err", 32'(len_err[k]), (len > 1500) ? 1 : 0);
                chk("first_tvalid", 32'(tvalid[k]), 1);
                chk("first_byte_idx", 32'(byte_idx[k]), 0);
            end else if (rnd) begin
                start[k] = 1'($urandom_range(0, 1));
            end
            cyc++;
            if (have_snap) begin
                chk("stall_tvalid", 32'(tvalid[k]), 1);
                chk("stall_hold", 32'(observe(k)), 32'(snap));
            end
            tready[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tvalid[k]) begin
                if (tready[k]) begin
                    have_snap = 0;
                    nbeats++;
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 32'(sb.size()), 1);
                    end else begin
                        chk("beat", 32'(observe(k)), 32'(sb.pop_front()));
                    end
                    if (tlast[k]) begin
                        done = 1;
                        last_idx = int'(byte_idx[k]);
                        last_keep = int'(tkeep[k]);
                    end
                end else begin
                    have_snap = 1;
                    snap = observe(k);
                end
            end
        end
        if (!rnd) start[k] = 1'b0;
        chk("frame_done", 32'(done), 1);
    endtask

    task automatic gap_check(input int k, input int exp, input bit pulse);
        int g = 0;
        bit ok = 1;
        bit seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (start_rdy[k]) begin
                seen = 1;
            end else begin
                g++;
                if (tvalid[k] || tkeep[k] != 8'd0 || !busy[k]) ok = 0;
                if (pulse) start[k] = 1'($urandom_range(0, 1));
            end
        end
        start[k] = 1'b0;
        chk("gap_len", 32'(g), 32'(exp));
        chk("gap_outs", 32'(ok), 1);
        if (pulse) begin
            @(negedge clk);
            chk("ignored_start", 32'(tvalid[k]), 0);
        end
    endtask

    initial begin
        int nb, li, lk;
        bit found;
        for (int k = 0; k < NI; k++) begin
            rst_n[k] = 1'b0; start[k] = 1'b0; tready[k] = 1'b0; payload_len[k] = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk("rst_start_rdy", 32'(start_rdy[k]), 1);
            chk("rst_outs", {4'd0, busy[k], tvalid[k], tlast[k], len_err[k], hdr_active[k],
                pay_start[k], pad_active[k], tkeep[k], byte_idx[k]}, 0);
            rst_n[k] = 1'b1;
        end

        run_frame(0, 100, 0, nb, li, lk);
        chk("t1_beats", 32'(nb), 114);
        chk("t1_last_idx", 32'(li), 113);
        gap_check(0, 12, 0);

        run_frame(1, 50, 0, nb, li, lk);
        chk("t2_beats", 32'(nb), 16);
        chk("t2_last_keep", 32'(lk), 32'h0F);
        gap_check(1, 12, 0);

        run_frame(2, 20, 0, nb, li, lk);
        chk("t3_beats", 32'(nb), 8);
        chk("t3_last_keep", 32'(lk), 32'h0F);
        gap_check(2, 12, 0);

        run_frame(0, 2000, 0, nb, li, lk);
        chk("t4_beats", 32'(nb), 1514);
        chk("t4_last_idx", 32'(li), 1513);
        gap_check(0, 12, 0);

        run_frame(3, 46, 1, nb, li, lk);
        chk("t5_beats", 32'(nb), 30);
        gap_check(3, 12, 1);

        start[0] = 1'b1; payload_len[0] = 16'd100; tready[0] = 1'b1;
        found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            start[0] = 1'b0;
            if (tvalid[0] && byte_idx[0] == 16'd40) found = 1;
        end
        chk("t6_reached_40", 32'(found), 1);
        rst_n[0] = 1'b0;
        @(negedge clk);
        chk("t6_tvalid", 32'(tvalid[0]), 0);
        chk("t6_start_rdy", 32'(start_rdy[0]), 1);
        chk("t6_busy_idx", {15'd0, busy[0], byte_idx[0]}, 0);
        rst_n[0] = 1'b1;
        run_frame(0, 0, 0, nb, li, lk);
        chk("t6_beats", 32'(nb), 60);
        gap_check(0, 12, 0);

        chk("sb_empty", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
